// File: rtl/hashin_pkg.sv
// hashin_pkg: shared state encoding, framing defaults and byte-swap helper for hashin_reader.
package hashin_pkg;

   localparam int          HDR_WORDS_DEF = 10;
   localparam logic [63:0] LEN_WORD_DEF  = 64'h8000000000000280;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WAIT_LEN = 3'd1,
      S_COLLECT  = 3'd2,
      S_CHECK    = 3'd3,
      S_PRESENT  = 3'd4
   } hashin_state_e;

   // The nonce FIFO carries the nonce in the opposite byte order to the header word.
   function automatic logic [31:0] bswap32(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

endpackage

// File: rtl/hashin_reader.sv
// hashin_reader: finds a length word in the hashin FIFO, collects the header words
// behind it, pairs the header with a nonce and presents both on a valid/ready port.
// Build option: define HASHIN_NONCE_CHECK_EN to drop frames whose low header word
// does not equal the byte-swapped nonce; otherwise every nonce is accepted.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | stopped; stop_ack_reader high, word counter cleared
// WAIT_LEN   | popping and discarding words until the length word shows up
// COLLECT    | shifting HDR_WORDS header words into hdr_data
// CHECK      | popping one nonce and (optionally) matching it to the header
// PRESENT    | hdr_valid high, hdr_data/hdr_nonce frozen until accepted
module hashin_reader import hashin_pkg::*; #(
   parameter int          HDR_WORDS = HDR_WORDS_DEF,
   parameter logic [63:0] LEN_WORD  = LEN_WORD_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [63:0]             hashin_fifo_out_dout,
   input  logic                    hashin_fifo_out_empty,
   output logic                    hashin_fifo_out_re,
   input  logic [31:0]             nonce_fifo_dout,
   input  logic                    nonce_fifo_empty,
   output logic                    nonce_fifo_re,
   output logic                    hdr_valid,
   input  logic                    hdr_ready,
   output logic [HDR_WORDS*64-1:0] hdr_data,
   output logic [31:0]             hdr_nonce,
   input  logic                    stop,
   output logic                    stop_ack_reader,
   output logic [15:0]             sync_err_cnt,
   output logic [15:0]             nonce_err_cnt
);

   localparam int             WCW      = $clog2(HDR_WORDS + 1);
   localparam logic [WCW-1:0] LAST_IDX = WCW'(HDR_WORDS - 1);

   localparam logic [2:0] ST_IDLE     = S_IDLE;
   localparam logic [2:0] ST_WAIT_LEN = S_WAIT_LEN;
   localparam logic [2:0] ST_COLLECT  = S_COLLECT;
   localparam logic [2:0] ST_CHECK    = S_CHECK;
   localparam logic [2:0] ST_PRESENT  = S_PRESENT;

   logic [2:0]     state, state_nxt;
   logic [WCW-1:0] word_cnt;
   logic           hash_pop, nonce_pop;
   logic           len_hit, nonce_ok;

   // Frame-start detect and nonce acceptance
   always_comb begin
      len_hit = (hashin_fifo_out_dout == LEN_WORD);
`ifdef HASHIN_NONCE_CHECK_EN
      nonce_ok = (hdr_data[31:0] == bswap32(nonce_fifo_dout));
`else
      nonce_ok = 1'b1;
`endif
   end

   // Next state and pops; reset or stop block every pop in the cycle they are seen
   always_comb begin
      state_nxt = state;
      hash_pop  = 1'b0;
      nonce_pop = 1'b0;
      if (rst || stop) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:     state_nxt = ST_WAIT_LEN;
            ST_WAIT_LEN: begin
               if (!hashin_fifo_out_empty) begin
                  hash_pop = 1'b1;
                  if (len_hit) state_nxt = ST_COLLECT;
               end
            end
            ST_COLLECT: begin
               if (!hashin_fifo_out_empty) begin
                  hash_pop = 1'b1;
                  if (word_cnt == LAST_IDX) state_nxt = ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (!nonce_fifo_empty) begin
                  nonce_pop = 1'b1;
                  state_nxt = nonce_ok ? ST_PRESENT : ST_WAIT_LEN;
               end
            end
            ST_PRESENT: begin
               if (hdr_ready) state_nxt = ST_WAIT_LEN;
            end
            default:     state_nxt = ST_IDLE;
         endcase
      end
   end

   assign hashin_fifo_out_re = hash_pop;
   assign nonce_fifo_re      = nonce_pop;
   assign hdr_valid          = (state == ST_PRESENT);
   assign stop_ack_reader    = (state == ST_IDLE);

   // State, word counter, header shift register, nonce capture and sync error count
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         word_cnt     <= '0;
         hdr_data     <= '0;
         hdr_nonce    <= '0;
         sync_err_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE) word_cnt <= '0;
         if (hash_pop) begin
            if (state == ST_WAIT_LEN) begin
               if (len_hit) begin
                  word_cnt <= '0;
               end else if (sync_err_cnt != 16'hFFFF) begin
                  sync_err_cnt <= sync_err_cnt + 16'd1;
               end
            end else begin
               hdr_data <= {hdr_data[HDR_WORDS*64-65:0], hashin_fifo_out_dout};
               word_cnt <= word_cnt + WCW'(1);
            end
         end
         if (nonce_pop) hdr_nonce <= nonce_fifo_dout;
      end
   end

`ifdef HASHIN_NONCE_CHECK_EN
   // Saturating count of frames dropped for a nonce mismatch
   always_ff @(posedge clk) begin
      if (rst) begin
         nonce_err_cnt <= '0;
      end else if (nonce_pop && !nonce_ok && (nonce_err_cnt != 16'hFFFF)) begin
         nonce_err_cnt <= nonce_err_cnt + 16'd1;
      end
   end
`else
   assign nonce_err_cnt = '0;
`endif

endmodule

// File: tb/tb_hashin_reader.sv
// tb_hashin_reader: directed checks of framing, nonce pairing, stalls, stop, reset and
// counter saturation for hashin_reader, with queue-backed FWFT FIFO models.
module tb_hashin_reader;

   localparam logic [63:0] LEN = 64'h8000000000000280;

   logic         clk, rst;
   logic [63:0]  hashin_fifo_out_dout;
   logic         hashin_fifo_out_empty, hashin_fifo_out_re;
   logic [31:0]  nonce_fifo_dout;
   logic         nonce_fifo_empty, nonce_fifo_re;
   logic         hdr_valid, hdr_ready;
   logic [639:0] hdr_data;
   logic [31:0]  hdr_nonce;
   logic         stop, stop_ack_reader;
   logic [15:0]  sync_err_cnt, nonce_err_cnt;

   hashin_reader dut (
      .clk                   (clk),
      .rst                   (rst),
      .hashin_fifo_out_dout  (hashin_fifo_out_dout),
      .hashin_fifo_out_empty (hashin_fifo_out_empty),
      .hashin_fifo_out_re    (hashin_fifo_out_re),
      .nonce_fifo_dout       (nonce_fifo_dout),
      .nonce_fifo_empty      (nonce_fifo_empty),
      .nonce_fifo_re         (nonce_fifo_re),
      .hdr_valid             (hdr_valid),
      .hdr_ready             (hdr_ready),
      .hdr_data              (hdr_data),
      .hdr_nonce             (hdr_nonce),
      .stop                  (stop),
      .stop_ack_reader       (stop_ack_reader),
      .sync_err_cnt          (sync_err_cnt),
      .nonce_err_cnt         (nonce_err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [63:0]  hq[$];
   logic [31:0]  nq[$];
   logic         h_gate;
   logic         last_hp;
   int           cyc, pops, hs_cnt, hs_cyc, last_pop_cyc, bad_cnt;
   int           n_assert, n_fail;
   int           p0, h0;
   logic [639:0] hs_data;
   logic [31:0]  hs_nonce;

   task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic refresh();
      hashin_fifo_out_empty = (hq.size() == 0) || h_gate;
      hashin_fifo_out_dout  = (hq.size() != 0) ? hq[0] : 64'h0;
      nonce_fifo_empty      = (nq.size() == 0);
      nonce_fifo_dout       = (nq.size() != 0) ? nq[0] : 32'h0;
   endtask

   // One clock: sample at the falling edge, apply pops after the rising edge.
   task automatic tick();
      logic hp, np, he, ne;
      @(negedge clk);
      hp = hashin_fifo_out_re;
      np = nonce_fifo_re;
      he = hashin_fifo_out_empty;
      ne = nonce_fifo_empty;
      last_hp = hp;
      if ((hp && he) || (np && ne) || (hp && np)) bad_cnt++;
      if (hp) begin
         pops++;
         last_pop_cyc = cyc;
      end
      if (hdr_valid && hdr_ready) begin
         hs_cnt++;
         hs_cyc   = cyc;
         hs_data  = hdr_data;
         hs_nonce = hdr_nonce;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (hp && !he && hq.size() != 0) void'(hq.pop_front());
      if (np && !ne && nq.size() != 0) void'(nq.pop_front());
      refresh();
      #1;
   endtask

   function automatic logic [63:0] fw(input logic [31:0] tag, input int k);
      return (k == 9) ? {tag, 32'h78563412} : {tag, 24'h0, 8'(k)};
   endfunction

   function automatic logic [639:0] fexp(input logic [31:0] tag);
      logic [639:0] e;
      e = '0;
      for (int k = 0; k < 10; k++) e[639-64*k -: 64] = fw(tag, k);
      return e;
   endfunction

   task automatic push_frame(input logic [31:0] tag, input int nwords);
      hq.push_back(LEN);
      for (int k = 0; k < nwords; k++) hq.push_back(fw(tag, k));
      refresh();
   endtask

   task automatic wait_hs(input int budget);
      int start;
      start = hs_cnt;
      for (int i = 0; i < budget && hs_cnt == start; i++) tick();
   endtask

   task automatic wait_pops(input int target, input int budget);
      for (int i = 0; i < budget && pops < target; i++) tick();
   endtask

   initial begin
      cyc = 0; pops = 0; hs_cnt = 0; hs_cyc = 0; last_pop_cyc = 0; bad_cnt = 0;
      n_assert = 0; n_fail = 0; last_hp = 1'b0; hs_data = '0; hs_nonce = '0;
      rst = 1'b1; stop = 1'b0; hdr_ready = 1'b1; h_gate = 1'b0;
      refresh();
      tick();
      tick();

      // reset state
      check("rst_valid",     hdr_valid, 0);
      check("rst_hash_re",   hashin_fifo_out_re, 0);
      check("rst_nonce_re",  nonce_fifo_re, 0);
      check("rst_stop_ack",  stop_ack_reader, 1);
      check("rst_sync_cnt",  sync_err_cnt, 0);
      check("rst_nonce_cnt", nonce_err_cnt, 0);
      check("rst_hdr_data",  hdr_data, 0);
      check("rst_hdr_nonce", hdr_nonce, 0);
      rst = 1'b0;
      check("post_rst_stop_ack", stop_ack_reader, 1);

      // basic frame, matching nonce
      p0 = pops;
      push_frame(32'hA1000000, 10);
      nq.push_back(32'h12345678);
      refresh();
      wait_hs(60);
      check("f1_hs_cnt",    hs_cnt, 1);
      check("f1_latency",   hs_cyc - last_pop_cyc, 2);
      check("f1_hdr_data",  hs_data, fexp(32'hA1000000));
      check("f1_hdr_nonce", hs_nonce, 32'h12345678);
      check("f1_nonce_err", nonce_err_cnt, 0);
      check("f1_pops",      pops - p0, 11);
      tick(); tick(); tick();
      check("f1_single_pulse", hs_cnt, 1);
      check("f1_valid_low",    hdr_valid, 0);
      check("f1_nonce_used",   nq.size(), 0);

      // mismatching nonce
      h0 = hs_cnt;
      push_frame(32'hA2000000, 10);
      nq.push_back(32'h00000001);
      refresh();
      wait_hs(40);
`ifdef HASHIN_NONCE_CHECK_EN
      check("f2_dropped",   hs_cnt - h0, 0);
      check("f2_nonce_err", nonce_err_cnt, 1);
`else
      check("f2_delivered", hs_cnt - h0, 1);
      check("f2_hdr_nonce", hs_nonce, 32'h00000001);
      check("f2_nonce_err", nonce_err_cnt, 0);
`endif
      check("f2_nonce_used", nq.size(), 0);

      // junk words ahead of a frame
      h0 = hs_cnt;
      hq.push_back(64'h1111);
      hq.push_back(64'h2222);
      hq.push_back(64'h3333);
      push_frame(32'hA3000000, 10);
      nq.push_back(32'h12345678);
      refresh();
      wait_hs(60);
      check("f3_sync_err",  sync_err_cnt, 3);
      check("f3_hs_cnt",    hs_cnt - h0, 1);
      check("f3_hdr_data",  hs_data, fexp(32'hA3000000));

      // gapped FIFO and consumer back-pressure
      hdr_ready = 1'b0;
      p0 = pops;
      push_frame(32'hA4000000, 10);
      nq.push_back(32'h12345678);
      for (int i = 0; i < 80 && !hdr_valid; i++) begin
         h_gate = (i % 2) == 1;
         refresh();
         tick();
      end
      h_gate = 1'b0;
      refresh();
      check("f4_valid_up", hdr_valid, 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("f4_stall_data",  hdr_data, fexp(32'hA4000000));
         check("f4_stall_valid", hdr_valid, 1);
      end
      check("f4_stall_nonce", hdr_nonce, 32'h12345678);
      hdr_ready = 1'b1;
      h0 = hs_cnt;
      tick();
      check("f4_hs_cnt", hs_cnt - h0, 1);
      check("f4_pops",   pops - p0, 11);
      tick();
      check("f4_valid_low", hdr_valid, 0);

      // stop after the fifth header word
      h0 = hs_cnt;
      p0 = pops;
      push_frame(32'hA5000000, 5);
      wait_pops(p0 + 6, 30);
      check("f5_partial_pops", pops - p0, 6);
      hq.push_back(64'h1);
      stop = 1'b1;
      refresh();
      tick();
      check("f5_stop_no_pop",  last_hp, 0);
      check("f5_stop_ack",     stop_ack_reader, 1);
      check("f5_stop_valid",   hdr_valid, 0);
      stop = 1'b0;
      push_frame(32'hA6000000, 10);
      nq.push_back(32'h12345678);
      refresh();
      wait_hs(60);
      check("f6_hs_cnt",   hs_cnt - h0, 1);
      check("f6_hdr_data", hs_data, fexp(32'hA6000000));
      check("f6_sync_err", sync_err_cnt, 4);

      // reset mid-frame
      p0 = pops;
      push_frame(32'hA7000000, 5);
      wait_pops(p0 + 3, 30);
      rst = 1'b1;
      tick();
      check("rst_mid_no_pop", last_hp, 0);
      rst = 1'b0;
      check("rst_mid_sync",     sync_err_cnt, 0);
      check("rst_mid_stop_ack", stop_ack_reader, 1);
      check("rst_mid_hdr_data", hdr_data, 0);
      hq.delete();
      refresh();

      // sync error counter saturation
      for (int i = 0; i < 65536; i++) hq.push_back(64'h5);
      refresh();
      for (int i = 0; i < 70000 && hq.size() != 0; i++) tick();
      check("sat_drained",  hq.size(), 0);
      check("sat_sync_err", sync_err_cnt, 16'hFFFF);

      check("fifo_protocol", bad_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/hashin_reader.md
HASHIN_READER -- requirements
Module: hashin_reader

Interface
REQ-001 SHALL have parameter HDR_WORDS, default 10, meaning 64-bit header words per frame after the length word.
REQ-002 SHALL have parameter LEN_WORD, default 64'h8000000000000280, meaning the frame-start length word.
REQ-003 SHALL have port clk, input, 1, global clock; one clock only.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have ports hashin_fifo_out_dout (input, 64, FWFT head word), hashin_fifo_out_empty (input, 1) and hashin_fifo_out_re (output, 1, pop).
REQ-006 SHALL have ports nonce_fifo_dout (input, 32, FWFT head nonce), nonce_fifo_empty (input, 1) and nonce_fifo_re (output, 1, pop).
REQ-007 SHALL have ports hdr_valid (output, 1), hdr_ready (input, 1), hdr_data (output, 640, assembled header) and hdr_nonce (output, 32, nonce paired with the header).
REQ-008 SHALL have ports stop (input, 1, abort request) and stop_ack_reader (output, 1, high while idle).
REQ-009 SHALL have ports sync_err_cnt (output, 16, discarded non-length words) and nonce_err_cnt (output, 16, frames dropped on nonce mismatch).

Function
REQ-010 SHALL implement states IDLE, WAIT_LEN, COLLECT, CHECK and PRESENT.
REQ-011 IDLE SHALL assert stop_ack_reader and clear the word counter, then go to WAIT_LEN on the next cycle if stop is low.
REQ-012 In WAIT_LEN with the FIFO not empty, it SHALL pop one word per cycle: LEN_WORD goes to COLLECT; any other word is discarded and increments sync_err_cnt.
REQ-013 In COLLECT, it SHALL pop one word per non-empty cycle and shift it in so that the first word lands in hdr_data[639:576] and the last in [63:0]. Empty FIFO means wait with no pop.
REQ-014 After the HDR_WORDS-th pop (cycle N), it SHALL be in CHECK at N+1.
REQ-015 CHECK SHALL wait while nonce_fifo_empty. Otherwise it SHALL pop one nonce, compare hdr_data[31:0] to the byte-swapped nonce, and go to PRESENT on a match.
REQ-016 On a mismatch, CHECK SHALL drop the frame, increment nonce_err_cnt and go to WAIT_LEN.
REQ-017 PRESENT SHALL hold hdr_valid high, registered, so best-case first assertion is N+2. hdr_data and hdr_nonce SHALL stay stable until the hdr_valid&&hdr_ready cycle, then go to WAIT_LEN.
REQ-018 The block SHALL never pop hashin and nonce FIFOs in the same cycle, and SHALL never pop an empty FIFO.
REQ-019 stop high in any state SHALL force IDLE on the next cycle with no pop in that cycle, discard any partial frame, and drop hdr_valid.
REQ-020 Error counters SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-021 The word counter SHALL be sized $clog2(HDR_WORDS+1) bits.

Reset
REQ-022 rst SHALL put the block in IDLE and clear hdr_data, hdr_nonce and both counters. hdr_valid, hashin_fifo_out_re and nonce_fifo_re SHALL be 0 and stop_ack_reader SHALL be 1 in the cycle after reset.
REQ-023 rst asserted mid-frame SHALL discard the frame, with no pop in the reset cycle.

Configuration
REQ-024 Macro HASHIN_NONCE_CHECK_EN defined: the CHECK compare of REQ-015/016 SHALL be active.
REQ-025 Macro HASHIN_NONCE_CHECK_EN undefined: CHECK SHALL pop the nonce and always go to PRESENT, and nonce_err_cnt SHALL be tied to 0.

Structure
REQ-026 Package hashin_pkg SHALL hold the state enum, the LEN_WORD default, the HDR_WORDS default and the bswap32 function.
REQ-027 The block SHALL have no sub-module; it is a single FSM with a datapath register.

Verification
REQ-028 LEN_WORD, 10 header words with word9[31:0]=32'h78563412, nonce 32'h12345678, hdr_ready=1 -> one hdr_valid pulse exactly 2 cycles after the last pop, hdr_nonce=32'h12345678, nonce_err_cnt=0.
REQ-029 Same frame with nonce 32'h00000001 -> no hdr_valid and nonce_err_cnt=1 with HASHIN_NONCE_CHECK_EN defined; hdr_valid with hdr_nonce=1 without the macro.
REQ-030 Three junk words, then a valid frame -> sync_err_cnt=3 and the frame is delivered intact.
REQ-031 hashin empty toggled every other cycle mid-frame, and hdr_ready held low for 5 cycles -> header correct, hdr_data stable while stalled, no extra pops.
REQ-032 stop pulsed after word 5 -> IDLE next cycle, stop_ack_reader=1, no hdr_valid; the following full frame is delivered correctly.
REQ-033 Force 65536 junk words -> sync_err_cnt holds at 16'hFFFF.
